// File: rtl/backend_flush_ctrl_pkg.sv
// Shared backend definitions for the flush/pause controller.
// Holds the flush FSM state encoding, the hold-counter width and the
// default issue-queue and flush-target counts used by backend blocks.
package backend_flush_ctrl_pkg;

  localparam int unsigned DEFAULT_NUM_IQ     = 3;   // ALU, LSU, MDU
  localparam int unsigned DEFAULT_NUM_STAGES = 16;
  localparam int unsigned HCNT_W             = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } flush_state_e;

endpackage

// File: rtl/backend_flush_ctrl_sat_counter.sv
// Saturating up-counter used for the backend performance counters.
// Ports:
//   clk   - clock
//   clear - synchronous clear (wins over inc)
//   inc   - increment request; ignored once the count is all-ones
//   count - current count
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/backend_flush_ctrl.sv
// Backend flush and pause controller.
// Generates the pipeline pause chain from queue/ROB/free-list status and a
// zero-latency flush that is held for FLUSH_HOLD cycles after the request,
// signalling rename-map recovery on the final hold cycle.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   flush_req             - commit-stage flush request
//   rob_pause_req         - ROB full
//   decode_pause_req      - decode stall request
//   iq_ready              - per-issue-queue space available
//   rename_allocatable    - free list non-empty
//   stage_flush, iq_flush - per-target flush (all bits equal)
//   rename_recover        - restore rename map from committed state
//   pause_*               - pipeline register stalls
//   flush_busy            - flush sequence in progress
//   stall_cycles          - cycles decode was stalled outside a flush
//   flush_count           - flush sequences started
module backend_flush_ctrl
  import backend_flush_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IQ     = DEFAULT_NUM_IQ,
  parameter int unsigned NUM_STAGES = DEFAULT_NUM_STAGES,
  parameter int unsigned FLUSH_HOLD = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_req,
  input  logic                  rob_pause_req,
  input  logic                  decode_pause_req,
  input  logic [NUM_IQ-1:0]     iq_ready,
  input  logic                  rename_allocatable,
  output logic [NUM_STAGES-1:0] stage_flush,
  output logic [NUM_IQ-1:0]     iq_flush,
  output logic                  rename_recover,
  output logic                  pause_ib_decode,
  output logic                  pause_decode_rename,
  output logic                  pause_rename,
  output logic                  pause_rename_dispatch,
  output logic                  pause_dispatch_iq,
  output logic                  flush_busy,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  localparam logic [HCNT_W-1:0] HOLD_LOAD = HCNT_W'(FLUSH_HOLD);
  localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(1);

  flush_state_e      state_q, state_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;

  logic iq_full;
  logic flush_active;
  logic flush_start;
  logic stall_inc;

  // Pause chain: purely combinational, independent of flush state.
  assign iq_full               = ~(&iq_ready);
  assign pause_dispatch_iq     = iq_full;
  assign pause_rename          = rob_pause_req | iq_full;
  assign pause_rename_dispatch = pause_rename;
  assign pause_decode_rename   = pause_rename | ~rename_allocatable;
  assign pause_ib_decode       = pause_decode_rename | decode_pause_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    unique case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = HOLD;
          hcnt_d  = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (flush_req) begin
          hcnt_d = HOLD_LOAD;
        end else if (hcnt_q == HCNT_ONE) begin
          state_d = IDLE;
          hcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_q - HCNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        hcnt_d  = '0;
      end
    endcase
  end

  // The held portion of the flush is masked during reset so that a reset
  // landing mid-sequence aborts it without a recover pulse; a live
  // flush_req still propagates with zero latency.
  always_comb begin
    logic in_hold;
    logic last_hold;
    in_hold        = (state_q == HOLD) && !rst;
    last_hold      = in_hold && (hcnt_q == HCNT_ONE);
    flush_active   = flush_req | in_hold;
    rename_recover = last_hold && !flush_req;
    // A request on the final hold cycle starts a new sequence rather than
    // extending the current one.
    flush_start    = flush_req && !rst && ((state_q == IDLE) || last_hold);
    stall_inc      = pause_ib_decode && !flush_active;
    stage_flush    = {NUM_STAGES{flush_active}};
    iq_flush       = {NUM_IQ{flush_active}};
    flush_busy     = flush_active;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (flush_start),
    .count (flush_count)
  );

endmodule

// File: tb/tb_backend_flush_ctrl.sv
// Scoreboard bench for backend_flush_ctrl. Three instances with different
// FLUSH_HOLD / CNT_W share one stimulus stream; a reference model based on
// "cycles since the last flush request" predicts every output.
module tb_backend_flush_ctrl;

  typedef struct packed {
    logic [15:0] sf;
    logic [2:0]  iqf;
    logic        rr;
    logic        busy;
    logic [4:0]  pause;
    logic [31:0] stall;
    logic [31:0] fcnt;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst, flush_req, rob_pause_req, decode_pause_req, rename_allocatable;
  logic [2:0] iq_ready;

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int hv[3] = '{1, 3, 4};
  int wv[3] = '{4, 32, 8};

  // model state
  bit     lv[3];
  int     lf[3];
  longint stall_m[3];
  longint fc_m[3];
  int     cyc = 0;

  obs_t exp_q[3][$];

  // DUT A: FLUSH_HOLD=1, CNT_W=4
  logic [15:0] sf_a; logic [2:0] iqf_a; logic rr_a, busy_a;
  logic pib_a, pdr_a, pr_a, prd_a, pdiq_a;
  logic [3:0] stall_a, fc_a;
  // DUT B: FLUSH_HOLD=3, CNT_W=32
  logic [15:0] sf_b; logic [2:0] iqf_b; logic rr_b, busy_b;
  logic pib_b, pdr_b, pr_b, prd_b, pdiq_b;
  logic [31:0] stall_b, fc_b;
  // DUT C: FLUSH_HOLD=4, CNT_W=8
  logic [15:0] sf_c; logic [2:0] iqf_c; logic rr_c, busy_c;
  logic pib_c, pdr_c, pr_c, prd_c, pdiq_c;
  logic [7:0] stall_c, fc_c;

  backend_flush_ctrl #(.NUM_IQ(3), .NUM_STAGES(16), .FLUSH_HOLD(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .flush_req(flush_req), .rob_pause_req(rob_pause_req),
    .decode_pause_req(decode_pause_req), .iq_ready(iq_ready),
    .rename_allocatable(rename_allocatable), .stage_flush(sf_a), .iq_flush(iqf_a),
    .rename_recover(rr_a), .pause_ib_decode(pib_a), .pause_decode_rename(pdr_a),
    .pause_rename(pr_a), .pause_rename_dispatch(prd_a), .pause_dispatch_iq(pdiq_a),
    .flush_busy(busy_a), .stall_cycles(stall_a), .flush_count(fc_a));

  backend_flush_ctrl #(.NUM_IQ(3), .NUM_STAGES(16), .FLUSH_HOLD(3), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .flush_req(flush_req), .rob_pause_req(rob_pause_req),
    .decode_pause_req(decode_pause_req), .iq_ready(iq_ready),
    .rename_allocatable(rename_allocatable), .stage_flush(sf_b), .iq_flush(iqf_b),
    .rename_recover(rr_b), .pause_ib_decode(pib_b), .pause_decode_rename(pdr_b),
    .pause_rename(pr_b), .pause_rename_dispatch(prd_b), .pause_dispatch_iq(pdiq_b),
    .flush_busy(busy_b), .stall_cycles(stall_b), .flush_count(fc_b));

  backend_flush_ctrl #(.NUM_IQ(3), .NUM_STAGES(16), .FLUSH_HOLD(4), .CNT_W(8)) dut_c (
    .clk(clk), .rst(rst), .flush_req(flush_req), .rob_pause_req(rob_pause_req),
    .decode_pause_req(decode_pause_req), .iq_ready(iq_ready),
    .rename_allocatable(rename_allocatable), .stage_flush(sf_c), .iq_flush(iqf_c),
    .rename_recover(rr_c), .pause_ib_decode(pib_c), .pause_decode_rename(pdr_c),
    .pause_rename(pr_c), .pause_rename_dispatch(prd_c), .pause_dispatch_iq(pdiq_c),
    .flush_busy(busy_c), .stall_cycles(stall_c), .flush_count(fc_c));

  function automatic obs_t get_obs(input int k);
    obs_t o;
    case (k)
      0: begin
        o.sf = sf_a; o.iqf = iqf_a; o.rr = rr_a; o.busy = busy_a;
        o.pause = {pib_a, pdr_a, pr_a, prd_a, pdiq_a};
        o.stall = 32'(stall_a); o.fcnt = 32'(fc_a);
      end
      1: begin
        o.sf = sf_b; o.iqf = iqf_b; o.rr = rr_b; o.busy = busy_b;
        o.pause = {pib_b, pdr_b, pr_b, prd_b, pdiq_b};
        o.stall = stall_b; o.fcnt = fc_b;
      end
      default: begin
        o.sf = sf_c; o.iqf = iqf_c; o.rr = rr_c; o.busy = busy_c;
        o.pause = {pib_c, pdr_c, pr_c, prd_c, pdiq_c};
        o.stall = 32'(stall_c); o.fcnt = 32'(fc_c);
      end
    endcase
    return o;
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%0h exp=%0h t=%0t", name, k, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per instance each cycle and compares.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (exp_q[k].size() > 0) begin
          obs_t e, a;
          e = exp_q[k].pop_front();
          a = get_obs(k);
          check("stage_flush",    k, 32'(a.sf),    32'(e.sf));
          check("iq_flush",       k, 32'(a.iqf),   32'(e.iqf));
          check("rename_recover", k, 32'(a.rr),    32'(e.rr));
          check("flush_busy",     k, 32'(a.busy),  32'(e.busy));
          check("pause_vec",      k, 32'(a.pause), 32'(e.pause));
          check("stall_cycles",   k, a.stall,      e.stall);
          check("flush_count",    k, a.fcnt,       e.fcnt);
        end
      end
    end
  end

  // Drive one cycle of inputs, predict outputs for that cycle, advance model.
  task automatic drive(input logic r, input logic f, input logic rb, input logic dc,
                       input logic ra, input logic [2:0] iq);
    logic iq_full, pren, pdr, pib;
    @(posedge clk);
    #1;
    rst = r; flush_req = f; rob_pause_req = rb; decode_pause_req = dc;
    rename_allocatable = ra; iq_ready = iq;
    iq_full = (iq != 3'b111);
    pren    = rb | iq_full;
    pdr     = pren | !ra;
    pib     = pdr | dc;
    for (int k = 0; k < 3; k++) begin
      obs_t   e;
      int     age;
      logic   in_hold, active, rec;
      longint maxv;
      maxv    = (64'd1 << wv[k]) - 1;
      age     = cyc - lf[k];
      in_hold = !r && lv[k] && (age >= 1) && (age <= hv[k]);
      active  = f || in_hold;
      rec     = in_hold && (age == hv[k]) && !f;
      e.sf    = {16{active}};
      e.iqf   = {3{active}};
      e.rr    = rec;
      e.busy  = active;
      e.pause = {pib, pdr, pren, pren, iq_full};
      e.stall = 32'(stall_m[k]);
      e.fcnt  = 32'(fc_m[k]);
      exp_q[k].push_back(e);
      if (r) begin
        lv[k] = 1'b0; stall_m[k] = 0; fc_m[k] = 0;
      end else begin
        if (f) begin
          if (!in_hold || age == hv[k]) fc_m[k] = (fc_m[k] == maxv) ? maxv : fc_m[k] + 1;
          lv[k] = 1'b1;
          lf[k] = cyc;
        end
        if (pib && !active) stall_m[k] = (stall_m[k] == maxv) ? maxv : stall_m[k] + 1;
      end
    end
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush_req = 1'b0; rob_pause_req = 1'b0; decode_pause_req = 1'b0;
    rename_allocatable = 1'b1; iq_ready = 3'b111;
    for (int k = 0; k < 3; k++) begin
      lv[k] = 1'b0; lf[k] = 0; stall_m[k] = 0; fc_m[k] = 0;
    end
    repeat (2) drive(1, 0, 0, 0, 1, 3'b111);
    repeat (3) drive(0, 0, 0, 0, 1, 3'b111);
    // single flush pulse
    drive(0, 1, 0, 0, 1, 3'b111);
    repeat (6) drive(0, 0, 0, 0, 1, 3'b111);
    // flush restarted two cycles later
    drive(0, 1, 0, 0, 1, 3'b111);
    drive(0, 0, 0, 0, 1, 3'b111);
    drive(0, 1, 0, 0, 1, 3'b111);
    repeat (8) drive(0, 0, 0, 0, 1, 3'b111);
    // pause chain patterns
    drive(0, 0, 0, 0, 1, 3'b101);
    drive(0, 0, 0, 0, 0, 3'b111);
    drive(0, 0, 1, 0, 1, 3'b111);
    drive(0, 0, 0, 1, 1, 3'b111);
    // long decode stall to saturate the narrow counter
    repeat (20) drive(0, 0, 0, 1, 1, 3'b111);
    // reset arriving mid-hold
    drive(0, 1, 0, 0, 1, 3'b111);
    drive(0, 0, 0, 0, 1, 3'b111);
    drive(1, 0, 0, 0, 1, 3'b111);
    repeat (6) drive(0, 0, 0, 0, 1, 3'b111);
    // random traffic
    repeat (3000) begin
      logic r, f, rb, dc, ra;
      logic [2:0] iq;
      r  = ($urandom_range(0, 99) == 0);
      f  = ($urandom_range(0, 5) == 0);
      rb = ($urandom_range(0, 3) == 0);
      dc = ($urandom_range(0, 3) == 0);
      ra = ($urandom_range(0, 4) != 0);
      iq = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
      drive(r, f, rb, dc, ra, iq);
    end
    repeat (3) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      check("drain", k, 32'(exp_q[k].size()), 32'd0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/backend_flush_ctrl.md
BACKEND_FLUSH_CTRL -- requirements
Module: backend_flush_ctrl

Interface
REQ-001 SHALL have parameter NUM_IQ, default 3: number of issue queues (ALU, LSU, MDU).
REQ-002 SHALL have parameter NUM_STAGES, default 16: number of pipeline-register/unit flush targets.
REQ-003 SHALL have parameter FLUSH_HOLD, default 1, range 1..15: cycles flush persists after the request cycle.
REQ-004 SHALL have parameter CNT_W, default 32: width of the performance counters.
REQ-005 SHALL have ports, in this order:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush_req  in  1  commit-stage flush request
- rob_pause_req  in  1  ROB full
- decode_pause_req  in  1  decode stall request
- iq_ready  in  NUM_IQ  per-queue space available
- rename_allocatable  in  1  free list non-empty
- stage_flush  out  NUM_STAGES  per-stage flush
- iq_flush  out  NUM_IQ  per-queue flush
- rename_recover  out  1  restore rename map from committed state
- pause_ib_decode  out  1  stall instbuffer->decode regs
- pause_decode_rename  out  1  stall decode->rename regs
- pause_rename  out  1  stall rename
- pause_rename_dispatch  out  1  stall rename->dispatch regs
- pause_dispatch_iq  out  1  stall dispatch->IQ regs
- flush_busy  out  1  flush sequence in progress
- stall_cycles  out  CNT_W  cycles with pause_ib_decode high
- flush_count  out  CNT_W  flush sequences started

Function
REQ-006 SHALL compute iq_full = NOT(AND of iq_ready).
REQ-007 SHALL drive pause_dispatch_iq = iq_full, combinationally.
REQ-008 SHALL drive pause_rename = pause_rename_dispatch = rob_pause_req OR iq_full.
REQ-009 SHALL drive pause_decode_rename = pause_rename OR NOT rename_allocatable.
REQ-010 SHALL drive pause_ib_decode = pause_decode_rename OR decode_pause_req.
REQ-011 SHALL keep pause outputs independent of flush state; consumers give flush priority.
REQ-012 SHALL implement FSM with states IDLE and HOLD, plus hold counter hcnt (4 bits).
REQ-013 IDLE, flush_req=1: next state HOLD, hcnt <= FLUSH_HOLD.
REQ-014 HOLD, flush_req=0: hcnt decrements; state returns to IDLE on the cycle hcnt=1.
REQ-015 HOLD, flush_req=1: hcnt reloads to FLUSH_HOLD; state stays HOLD (restart).
REQ-016 flush_active = flush_req OR (state==HOLD); all stage_flush and iq_flush bits SHALL equal flush_active, same cycle as flush_req (zero latency).
REQ-017 flush_busy SHALL equal flush_active.
REQ-018 rename_recover SHALL be 1 only when state==HOLD, hcnt==1 and flush_req=0 (last hold cycle); it is suppressed when a restart occurs.
REQ-019 With FLUSH_HOLD=1: flush high in cycles T and T+1, rename_recover high in T+1 only.
REQ-020 flush_count SHALL increment on a flush_req cycle when state==IDLE or rename_recover would have fired; restarts within HOLD SHALL NOT count.
REQ-021 stall_cycles SHALL increment each cycle pause_ib_decode=1 and flush_active=0.
REQ-022 Both counters SHALL saturate at all-ones, never wrap.

Reset
REQ-023 On rst: state=IDLE, hcnt=0, counters=0, rename_recover=0; flush outputs and flush_busy follow flush_req combinationally.
REQ-024 rst asserted mid-HOLD SHALL abort the sequence without asserting rename_recover.

Structure
REQ-025 SHALL place the FSM state enum and default NUM_IQ/NUM_STAGES constants in the shared backend package.
REQ-026 SHALL instantiate one sub-module, sat_counter (parameter W, inc, clear), twice, for the counters.

Verification
REQ-027 FLUSH_HOLD=1, flush_req pulse at T: stage_flush=all-ones at T,T+1; rename_recover=1 at T+1 only; flush_count=1.
REQ-028 FLUSH_HOLD=3, flush_req at T and again at T+2: flush high T..T+5, rename_recover only at T+5, flush_count=1.
REQ-029 iq_ready=3'b101, others idle: pause_dispatch_iq=pause_rename=pause_ib_decode=1; rename_allocatable=0 alone: pause_decode_rename=1, pause_rename=0.
REQ-030 CNT_W=4, pause_ib_decode held 20 cycles: stall_cycles reaches 15 and holds.
REQ-031 FLUSH_HOLD=4, rst at T+2 after flush_req at T: state IDLE at T+3, rename_recover never asserted.
